// File: rtl/rd_bin_info_stream.sv
// Bin-info header reader: reassembles var count and clause-bin count from narrow
// little-endian beats, range-checks them and latches validated values for the bin manager.
module rd_bin_info_stream #(
    parameter int WIDTH_DATA    = 8,
    parameter int WIDTH_VARS    = 12,
    parameter int WIDTH_CLAUSES = 16,
    parameter int MAX_VARS      = 2048,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_rdinfo_i,
    output logic                     done_rdinfo_o,
    output logic                     err_rdinfo_o,
    output logic                     busy_o,
    output logic                     rd_req_o,
    input  logic                     data_en,
    input  logic [WIDTH_DATA-1:0]    data_i,
    output logic [WIDTH_VARS-1:0]    nv_all_o,
    output logic [WIDTH_CLAUSES-1:0] n_cbin_o,
    output logic                     info_valid_o
);

    localparam int NV_BEATS  = (WIDTH_VARS + WIDTH_DATA - 1) / WIDTH_DATA;
    localparam int NB_BEATS  = (WIDTH_CLAUSES + WIDTH_DATA - 1) / WIDTH_DATA;
    localparam int TOT_BEATS = NV_BEATS + NB_BEATS;
    localparam int CNT_W     = $clog2(TOT_BEATS + 1);
    localparam int TO_W      = $clog2(TIMEOUT + 1);

    localparam logic [TO_W-1:0]       TIMEOUT_C  = TO_W'(TIMEOUT);
    localparam logic [WIDTH_VARS:0]   MAX_VARS_C = (WIDTH_VARS + 1)'(MAX_VARS);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(TOT_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
    logic [WIDTH_VARS-1:0]    nv_q, nv_d;
    logic [WIDTH_CLAUSES-1:0] nb_q, nb_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     rd_req_q, rd_req_d;
    logic [WIDTH_VARS-1:0]    nv_all_q, nv_all_d;
    logic [WIDTH_CLAUSES-1:0] n_cbin_q, n_cbin_d;
    logic                     info_valid_q, info_valid_d;

    logic                     beat_acc_s;
    logic                     chk_err_s;
    logic [TO_W-1:0]          to_inc_s;

    // rd_req_q is high exactly while the FSM sits in RECV, so it gates acceptance
    assign beat_acc_s = data_en && rd_req_q;
    assign to_inc_s   = to_cnt_q + TO_W'(1'b1);
    assign chk_err_s  = (nv_q == {WIDTH_VARS{1'b0}})
                     || ({1'b0, nv_q} > MAX_VARS_C)
                     || (nb_q == {WIDTH_CLAUSES{1'b0}});

    // Next-state, beat assembly and registered-output next values
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        to_cnt_d     = to_cnt_q;
        nv_d         = nv_q;
        nb_d         = nb_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        nv_all_d     = nv_all_q;
        n_cbin_d     = n_cbin_q;
        info_valid_d = info_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start_rdinfo_i) begin
                    state_d      = S_RECV;
                    beat_cnt_d   = {CNT_W{1'b0}};
                    to_cnt_d     = {TO_W{1'b0}};
                    nv_d         = {WIDTH_VARS{1'b0}};
                    nb_d         = {WIDTH_CLAUSES{1'b0}};
                    info_valid_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RECV: begin
                if (beat_acc_s) begin
                    to_cnt_d = {TO_W{1'b0}};
                    // Bit-wise fill drops the excess bits of each field's last beat
                    for (int b = 0; b < WIDTH_VARS; b++) begin
                        nv_d[b] = (beat_cnt_q == CNT_W'(b / WIDTH_DATA))
                                ? data_i[b % WIDTH_DATA] : nv_q[b];
                    end
                    for (int b = 0; b < WIDTH_CLAUSES; b++) begin
                        nb_d[b] = (beat_cnt_q == CNT_W'(NV_BEATS + b / WIDTH_DATA))
                                ? data_i[b % WIDTH_DATA] : nb_q[b];
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_CHECK;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1'b1);
                    end
                end else if (to_inc_s == TIMEOUT_C) begin
                    state_d      = S_DONE;
                    to_cnt_d     = {TO_W{1'b0}};
                    done_d       = 1'b1;
                    err_d        = 1'b1;
                    info_valid_d = 1'b0;
                end else begin
                    to_cnt_d = to_inc_s;
                end
            end
            S_CHECK: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                err_d   = chk_err_s;
                if (chk_err_s) begin
                    info_valid_d = 1'b0;
                end else begin
                    nv_all_d     = nv_q;
                    n_cbin_d     = nb_q;
                    info_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d   = (state_d != S_IDLE);
        rd_req_d = (state_d == S_RECV);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= {CNT_W{1'b0}};
            to_cnt_q     <= {TO_W{1'b0}};
            nv_q         <= {WIDTH_VARS{1'b0}};
            nb_q         <= {WIDTH_CLAUSES{1'b0}};
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            nv_all_q     <= {WIDTH_VARS{1'b0}};
            n_cbin_q     <= {WIDTH_CLAUSES{1'b0}};
            info_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            to_cnt_q     <= to_cnt_d;
            nv_q         <= nv_d;
            nb_q         <= nb_d;
            done_q       <= done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            rd_req_q     <= rd_req_d;
            nv_all_q     <= nv_all_d;
            n_cbin_q     <= n_cbin_d;
            info_valid_q <= info_valid_d;
        end
    end

    assign done_rdinfo_o = done_q;
    assign err_rdinfo_o  = err_q;
    assign busy_o        = busy_q;
    assign rd_req_o      = rd_req_q;
    assign nv_all_o      = nv_all_q;
    assign n_cbin_o      = n_cbin_q;
    assign info_valid_o  = info_valid_q;

endmodule

// File: tb/tb_rd_bin_info_stream.sv
// Directed bench for rd_bin_info_stream with TIMEOUT=4; inputs change #1 after
// the rising edge and outputs are sampled at that same point.
module tb_rd_bin_info_stream;

    logic        clk;
    logic        rst;
    logic        start_rdinfo_i;
    logic        done_rdinfo_o;
    logic        err_rdinfo_o;
    logic        busy_o;
    logic        rd_req_o;
    logic        data_en;
    logic [7:0]  data_i;
    logic [11:0] nv_all_o;
    logic [15:0] n_cbin_o;
    logic        info_valid_o;

    int errors = 0;
    int checks = 0;

    logic [7:0] s2_beats [4] = '{8'h34, 8'h02, 8'h10, 8'h00};

    rd_bin_info_stream #(
        .WIDTH_DATA   (8),
        .WIDTH_VARS   (12),
        .WIDTH_CLAUSES(16),
        .MAX_VARS     (2048),
        .TIMEOUT      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_rdinfo_i(start_rdinfo_i),
        .done_rdinfo_o (done_rdinfo_o),
        .err_rdinfo_o  (err_rdinfo_o),
        .busy_o        (busy_o),
        .rd_req_o      (rd_req_o),
        .data_en       (data_en),
        .data_i        (data_i),
        .nv_all_o      (nv_all_o),
        .n_cbin_o      (n_cbin_o),
        .info_valid_o  (info_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_done(input string tag, input logic e, input logic [11:0] nv,
                            input logic [15:0] nb, input logic v);
        chk({tag, "_done"},  {31'd0, done_rdinfo_o}, 32'd1);
        chk({tag, "_err"},   {31'd0, err_rdinfo_o},  {31'd0, e});
        chk({tag, "_nv"},    {20'd0, nv_all_o},      {20'd0, nv});
        chk({tag, "_nb"},    {16'd0, n_cbin_o},      {16'd0, nb});
        chk({tag, "_valid"}, {31'd0, info_valid_o},  {31'd0, v});
    endtask

    // Start a read, feed four consecutive beats, return positioned in the DONE cycle
    task automatic do_read(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        start_rdinfo_i = 1'b1;
        tick();
        start_rdinfo_i = 1'b0;
        data_en = 1'b1;
        data_i  = b0; tick();
        data_i  = b1; tick();
        data_i  = b2; tick();
        data_i  = b3; tick();
        data_en = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_rdinfo_i = 1'b0;
        data_en = 1'b0;
        data_i = 8'h00;
        tick();
        tick();
        chk("rst_done",  {31'd0, done_rdinfo_o}, 32'd0);
        chk("rst_err",   {31'd0, err_rdinfo_o},  32'd0);
        chk("rst_busy",  {31'd0, busy_o},        32'd0);
        chk("rst_req",   {31'd0, rd_req_o},      32'd0);
        chk("rst_nv",    {20'd0, nv_all_o},      32'd0);
        chk("rst_nb",    {16'd0, n_cbin_o},      32'd0);
        chk("rst_valid", {31'd0, info_valid_o},  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // 1: normal back-to-back read
        start_rdinfo_i = 1'b1;
        tick();
        chk("s1_req_t1",  {31'd0, rd_req_o}, 32'd1);
        chk("s1_busy_t1", {31'd0, busy_o},   32'd1);
        start_rdinfo_i = 1'b0;
        data_en = 1'b1;
        data_i = 8'h34; tick();
        data_i = 8'h02; tick();
        data_i = 8'h10; tick();
        data_i = 8'h00; tick();
        data_en = 1'b0;
        chk("s1_c1_done", {31'd0, done_rdinfo_o}, 32'd0);
        chk("s1_c1_req",  {31'd0, rd_req_o},      32'd0);
        chk("s1_c1_busy", {31'd0, busy_o},        32'd1);
        tick();
        chk_done("s1", 1'b0, 12'h234, 16'h0010, 1'b1);
        tick();
        chk("s1_post_done", {31'd0, done_rdinfo_o}, 32'd0);
        chk("s1_post_busy", {31'd0, busy_o},        32'd0);
        chk("s1_post_valid", {31'd0, info_valid_o}, 32'd1);

        // 2: gapped read, rd_req stays high through the gaps
        start_rdinfo_i = 1'b1;
        tick();
        start_rdinfo_i = 1'b0;
        chk("s2_valid_clr", {31'd0, info_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            data_en = 1'b1;
            data_i  = s2_beats[k];
            tick();
            data_en = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < 3; g++) begin
                    chk("s2_gap_req",  {31'd0, rd_req_o},      32'd1);
                    chk("s2_gap_done", {31'd0, done_rdinfo_o}, 32'd0);
                    tick();
                end
            end
        end
        tick();
        chk_done("s2", 1'b0, 12'h234, 16'h0010, 1'b1);
        tick();

        // 3: range errors and the legal upper boundary
        do_read(8'h01, 8'h09, 8'h05, 8'h00);
        chk_done("s3_big", 1'b1, 12'h234, 16'h0010, 1'b0);
        tick();
        do_read(8'h00, 8'h00, 8'h05, 8'h00);
        chk_done("s3_nv0", 1'b1, 12'h234, 16'h0010, 1'b0);
        tick();
        do_read(8'h00, 8'hF8, 8'h01, 8'h00);
        chk_done("s3_max", 1'b0, 12'h800, 16'h0001, 1'b1);
        tick();
        do_read(8'h05, 8'h00, 8'h00, 8'h00);
        chk_done("s3_nb0", 1'b1, 12'h800, 16'h0001, 1'b0);
        tick();

        // 4: timeout after one beat
        start_rdinfo_i = 1'b1;
        tick();
        start_rdinfo_i = 1'b0;
        data_en = 1'b1;
        data_i  = 8'hAA;
        tick();
        data_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("s4_idle_done", {31'd0, done_rdinfo_o}, 32'd0);
            chk("s4_idle_req",  {31'd0, rd_req_o},      32'd1);
            tick();
        end
        chk_done("s4", 1'b1, 12'h800, 16'h0001, 1'b0);
        chk("s4_req", {31'd0, rd_req_o}, 32'd0);
        tick();
        chk("s4_idle_busy", {31'd0, busy_o},        32'd0);
        chk("s4_post_done", {31'd0, done_rdinfo_o}, 32'd0);

        // 5: stray beats in IDLE/CHECK, start held high across a whole read
        data_en = 1'b1;
        data_i  = 8'hFF;
        tick();
        chk("s5_stray_req",  {31'd0, rd_req_o}, 32'd0);
        chk("s5_stray_busy", {31'd0, busy_o},   32'd0);
        tick();
        data_en = 1'b0;
        chk("s5_stray_nv", {20'd0, nv_all_o}, 32'h800);
        start_rdinfo_i = 1'b1;
        tick();
        data_en = 1'b1;
        data_i = 8'h21; tick();
        data_i = 8'h03; tick();
        data_i = 8'h07; tick();
        data_i = 8'h00; tick();
        data_i = 8'hFF;
        chk("s5_chk_done", {31'd0, done_rdinfo_o}, 32'd0);
        tick();
        data_en = 1'b0;
        chk_done("s5", 1'b0, 12'h321, 16'h0007, 1'b1);
        tick();
        chk("s5_idle_busy", {31'd0, busy_o},        32'd0);
        chk("s5_idle_done", {31'd0, done_rdinfo_o}, 32'd0);
        tick();
        chk("s5_restart_busy", {31'd0, busy_o},   32'd1);
        chk("s5_restart_req",  {31'd0, rd_req_o}, 32'd1);
        start_rdinfo_i = 1'b0;
        data_en = 1'b1;
        data_i = 8'h34; tick();
        data_i = 8'h02; tick();
        data_i = 8'h10; tick();
        data_i = 8'h00; tick();
        data_en = 1'b0;
        tick();
        chk_done("s5b", 1'b0, 12'h234, 16'h0010, 1'b1);
        tick();
        chk("s5b_post_done", {31'd0, done_rdinfo_o}, 32'd0);

        // 6: reset in the middle of a read
        start_rdinfo_i = 1'b1;
        tick();
        start_rdinfo_i = 1'b0;
        data_en = 1'b1;
        data_i = 8'h11; tick();
        data_i = 8'h01; tick();
        data_en = 1'b0;
        rst = 1'b1;
        tick();
        chk("s6_done",  {31'd0, done_rdinfo_o}, 32'd0);
        chk("s6_err",   {31'd0, err_rdinfo_o},  32'd0);
        chk("s6_busy",  {31'd0, busy_o},        32'd0);
        chk("s6_req",   {31'd0, rd_req_o},      32'd0);
        chk("s6_nv",    {20'd0, nv_all_o},      32'd0);
        chk("s6_nb",    {16'd0, n_cbin_o},      32'd0);
        chk("s6_valid", {31'd0, info_valid_o},  32'd0);
        rst = 1'b0;
        tick();
        chk("s6_idle_busy", {31'd0, busy_o}, 32'd0);
        do_read(8'h34, 8'h02, 8'h10, 8'h00);
        chk_done("s6_fresh", 1'b0, 12'h234, 16'h0010, 1'b1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
